// File: rtl/yourcpu_pkg.sv
// Shared decode constants and ALU operation encoding for the your_cpu RV32I core.
package yourcpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

endpackage

// File: rtl/yourcpu_alu.sv
// Combinational integer ALU; shift amounts use only the low 5 bits of b.
module yourcpu_alu
    import yourcpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << b[4:0];
            ALU_SLT:   y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {31'b0, a < b};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> b[4:0];
            ALU_SRA:   y = $signed(a) >>> b[4:0];
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/your_cpu.sv
// Single-cycle RV32I core with internal IMEM/DMEM/register file.
// Optional YOURCPU_HALT_EN: ECALL/EBREAK freeze the core until reset.
module your_cpu
    import yourcpu_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] tb_addr,
    input  logic [31:0] tb_inst
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [31:0] rf   [0:31];
    logic [31:0] pc, pc_d, pc_seq, pc_plus4;
    logic        halted, halt_req, freeze;

    logic [31:0] inst, rs1_val, rs2_val;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_y;
    logic        alu_ok;

    logic [31:0] mem_word, load_data, store_word, wb_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        rf_we, dmem_we, br_taken;

    logic        unused_tb_addr;
    assign unused_tb_addr = ^{tb_addr[31:IAW+2], tb_addr[1:0]};

    assign inst     = imem[pc[IAW+1:2]];
    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign funct3   = inst[14:12];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign funct7   = inst[31:25];
    assign rs1_val  = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : rf[rs2];
    assign pc_plus4 = pc + 32'd4;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // ALU control; loads, stores and JALR reuse the adder for address generation.
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_i;
        alu_ok = 1'b0;
        case (opcode)
            OP_LUI: begin
                alu_op = ALU_PASSB;
                alu_b  = imm_u;
            end
            OP_STORE: alu_b = imm_s;
            OP_IMM, OP_OP: begin
                if (opcode == OP_OP) alu_b = rs2_val;
                case (funct3)
                    3'b000:  alu_op = (opcode == OP_OP && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
                if (opcode == OP_OP)
                    alu_ok = (funct7 == 7'd0) ||
                             (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
                else if (funct3 == 3'b001)
                    alu_ok = (funct7 == 7'd0);
                else if (funct3 == 3'b101)
                    alu_ok = (funct7 == 7'd0) || (funct7 == F7_ALT);
                else
                    alu_ok = 1'b1;
            end
            default: ;
        endcase
    end

    yourcpu_alu u_alu (
        .a  (rs1_val),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    assign mem_word = dmem[alu_y[DAW+1:2]];
    assign ld_half  = alu_y[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        case (alu_y[1:0])
            2'd0:    ld_byte = mem_word[7:0];
            2'd1:    ld_byte = mem_word[15:8];
            2'd2:    ld_byte = mem_word[23:16];
            default: ld_byte = mem_word[31:24];
        endcase
        case (funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   load_data = {24'b0, ld_byte};
            F3_HU:   load_data = {16'b0, ld_half};
            default: load_data = mem_word;
        endcase
    end

    // Stores are a read-modify-write of the addressed word so only the selected lanes change.
    always_comb begin
        store_word = mem_word;
        case (funct3)
            F3_B: begin
                case (alu_y[1:0])
                    2'd0:    store_word[7:0]   = rs2_val[7:0];
                    2'd1:    store_word[15:8]  = rs2_val[7:0];
                    2'd2:    store_word[23:16] = rs2_val[7:0];
                    default: store_word[31:24] = rs2_val[7:0];
                endcase
            end
            F3_H: begin
                if (alu_y[1]) store_word[31:16] = rs2_val[15:0];
                else          store_word[15:0]  = rs2_val[15:0];
            end
            default: store_word = rs2_val;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val < rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        rf_we   = 1'b0;
        dmem_we = 1'b0;
        wb_data = alu_y;
        pc_seq  = pc_plus4;
        case (opcode)
            OP_LUI:        rf_we = 1'b1;
            OP_IMM, OP_OP: rf_we = alu_ok;
            OP_AUIPC: begin
                rf_we   = 1'b1;
                wb_data = pc + imm_u;
            end
            OP_JAL: begin
                rf_we   = 1'b1;
                wb_data = pc_plus4;
                pc_seq  = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rf_we   = 1'b1;
                    wb_data = pc_plus4;
                    pc_seq  = {alu_y[31:1], 1'b0};
                end
            end
            OP_BRANCH: if (br_taken) pc_seq = pc + imm_b;
            OP_LOAD: begin
                rf_we   = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                          (funct3 == F3_BU) || (funct3 == F3_HU);
                wb_data = load_data;
            end
            OP_STORE: dmem_we = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
            OP_FENCE: ;
            default: ;
        endcase
    end

`ifdef YOURCPU_HALT_EN
    assign halt_req = (opcode == OP_SYSTEM);

    always_ff @(posedge clk) begin
        if (reset_n) halted <= 1'b0;
        else         halted <= halted | halt_req;
    end
`else
    assign halt_req = 1'b0;
    assign halted   = 1'b0;
`endif

    assign freeze = halted | halt_req;
    assign pc_d   = freeze ? pc : pc_seq;

    always_ff @(posedge clk) begin
        if (reset_n) pc <= RESET_PC;
        else         pc <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we && !freeze && rd != 5'd0) begin
            rf[rd] <= wb_data;
        end
    end

    // IMEM is only writable while reset is held; DMEM survives reset.
    always_ff @(posedge clk) begin
        if (reset_n) imem[tb_addr[IAW+1:2]] <= tb_inst;
    end

    always_ff @(posedge clk) begin
        if (!reset_n && dmem_we && !freeze) dmem[alu_y[DAW+1:2]] <= store_word;
    end

endmodule

// File: tb/tb_your_cpu.sv
// Scoreboard bench for your_cpu: directed programs, expectations queued and checked by a monitor.
module tb_your_cpu;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [6:0]  O_IMM   = 7'b0010011;
    localparam logic [6:0]  O_LOAD  = 7'b0000011;
    localparam logic [6:0]  O_LUI   = 7'b0110111;
    localparam logic [6:0]  O_AUIPC = 7'b0010111;
    localparam logic [6:0]  O_JALR  = 7'b1100111;
    localparam int K_RF = 0, K_PC = 1, K_MEM = 2, K_HALT = 3;

    logic        clk;
    logic        reset_n;
    logic [31:0] tb_addr;
    logic [31:0] tb_inst;

    your_cpu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tb_addr (tb_addr),
        .tb_inst (tb_inst)
    );

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] prog[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          total = 0;
    int          bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    // Holds reset while every IMEM word is written; unused words become NOPs.
    task automatic load_program();
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tb_addr = 32'(i * 4);
            tb_inst = (i < prog.size()) ? prog[i] : NOP;
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
    endtask

    task automatic run_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(string name, int kind, int idx, logic [31:0] exp);
        sb_q.push_back('{name, kind, idx, exp});
    endtask

    // The monitor empties the queue on the negedge; anything left over was never checked.
    task automatic drain();
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
                K_RF:    mon_act = dut.rf[mon_e.idx];
                K_PC:    mon_act = dut.pc;
                K_MEM:   mon_act = dut.dmem[mon_e.idx];
                default: mon_act = {31'b0, dut.halted};
            endcase
            total++;
            if (mon_act !== mon_e.exp) begin
                bad++;
                $display("[TB] FAIL %s: actual=%h expected=%h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        tb_addr = '0;
        tb_inst = NOP;

        // Arithmetic, shifts, compares, unknown opcode and x0 writes
        prog = '{enc_i(5, 0, 0, 1, O_IMM), enc_i(-3, 0, 0, 2, O_IMM), enc_r(0, 2, 1, 0, 3),
                 enc_r(32, 1, 2, 0, 4), enc_i(32'h401, 2, 5, 6, O_IMM), enc_i(28, 2, 5, 7, O_IMM),
                 enc_r(0, 1, 2, 2, 8), enc_r(0, 1, 2, 3, 9), enc_i(33, 0, 0, 13, O_IMM),
                 enc_r(0, 13, 1, 1, 14), 32'hFFFF_FFFF, enc_i(7, 0, 0, 0, O_IMM), enc_j(0, 0)};
        load_program();
        expect_v("reset_pc", K_PC, 0, 32'h0);
        expect_v("reset_x3", K_RF, 3, 32'h0);
        drain();
        run_cycles(3);
        expect_v("add_x3", K_RF, 3, 32'h2);
        expect_v("add_pc", K_PC, 0, 32'd12);
        expect_v("addi_neg_x2", K_RF, 2, 32'hFFFF_FFFD);
        drain();
        run_cycles(12);
        expect_v("sub_x4", K_RF, 4, 32'hFFFF_FFF8);
        expect_v("srai_x6", K_RF, 6, 32'hFFFF_FFFE);
        expect_v("srli_x7", K_RF, 7, 32'h0000_000F);
        expect_v("slt_x8", K_RF, 8, 32'h1);
        expect_v("sltu_x9", K_RF, 9, 32'h0);
        expect_v("sll_wrap_x14", K_RF, 14, 32'd10);
        expect_v("unknown_x31", K_RF, 31, 32'h0);
        expect_v("x0_zero", K_RF, 0, 32'h0);
        expect_v("park_pc1", K_PC, 0, 32'd48);
        drain();

        // Loads/stores: byte and half lanes, sign/zero extension, misaligned word
        prog = '{enc_u(32'h12345, 5, O_LUI), enc_i(32'h678, 5, 0, 5, O_IMM), enc_s(8, 5, 0, 2),
                 enc_i(8, 0, 0, 6, O_LOAD), enc_i(11, 0, 4, 7, O_LOAD), enc_s(12, 0, 0, 2),
                 enc_i(-128, 0, 0, 8, O_IMM), enc_s(13, 8, 0, 0), enc_i(13, 0, 0, 9, O_LOAD),
                 enc_i(12, 0, 5, 10, O_LOAD), enc_s(14, 8, 0, 1), enc_i(14, 0, 1, 11, O_LOAD),
                 enc_i(9, 0, 2, 12, O_LOAD), enc_u(1, 13, O_AUIPC), enc_j(0, 0)};
        load_program();
        run_cycles(15);
        expect_v("sw_dmem2", K_MEM, 2, 32'h1234_5678);
        expect_v("lb_x6", K_RF, 6, 32'h0000_0078);
        expect_v("lbu_x7", K_RF, 7, 32'h0000_0012);
        expect_v("lb_neg_x9", K_RF, 9, 32'hFFFF_FF80);
        expect_v("lhu_x10", K_RF, 10, 32'h0000_8000);
        expect_v("sb_sh_dmem3", K_MEM, 3, 32'hFF80_8000);
        expect_v("lh_x11", K_RF, 11, 32'hFFFF_FF80);
        expect_v("lw_misalign_x12", K_RF, 12, 32'h1234_5678);
        expect_v("auipc_x13", K_RF, 13, 32'h0000_1034);
        expect_v("park_pc2", K_PC, 0, 32'd56);
        drain();

        // Signed vs unsigned branches
        prog = '{enc_i(-1, 0, 0, 1, O_IMM), enc_i(1, 0, 0, 2, O_IMM), enc_b(8, 2, 1, 4),
                 enc_i(1, 0, 0, 10, O_IMM), enc_b(8, 2, 1, 6), enc_i(1, 0, 0, 11, O_IMM),
                 enc_b(8, 2, 1, 7), enc_i(1, 0, 0, 12, O_IMM), enc_b(8, 1, 1, 1),
                 enc_j(0, 0), enc_j(0, 0)};
        load_program();
        run_cycles(3);
        expect_v("blt_taken_pc", K_PC, 0, 32'd16);
        drain();
        run_cycles(1);
        expect_v("bltu_not_taken_pc", K_PC, 0, 32'd20);
        drain();
        run_cycles(4);
        expect_v("branch_end_pc", K_PC, 0, 32'd36);
        expect_v("blt_skip_x10", K_RF, 10, 32'h0);
        expect_v("bltu_fall_x11", K_RF, 11, 32'h1);
        expect_v("bgeu_skip_x12", K_RF, 12, 32'h0);
        drain();

        // JAL/JALR, then reset mid-run
        prog = '{enc_i(3, 0, 0, 5, O_IMM), enc_j(16, 1), enc_i(9, 0, 0, 6, O_IMM), enc_j(0, 0),
                 NOP, enc_i(1, 1, 0, 0, O_JALR)};
        load_program();
        run_cycles(2);
        expect_v("jal_pc", K_PC, 0, 32'd20);
        expect_v("jal_link_x1", K_RF, 1, 32'd8);
        drain();
        run_cycles(1);
        expect_v("jalr_pc", K_PC, 0, 32'd8);
        drain();
        run_cycles(2);
        expect_v("after_jalr_x6", K_RF, 6, 32'd9);
        expect_v("after_jalr_pc", K_PC, 0, 32'd12);
        drain();
        reset_n = 1'b1;
        run_cycles(1);
        reset_n = 1'b0;
        expect_v("midreset_pc", K_PC, 0, 32'h0);
        expect_v("midreset_x1", K_RF, 1, 32'h0);
        expect_v("midreset_x6", K_RF, 6, 32'h0);
        expect_v("midreset_dmem2", K_MEM, 2, 32'h1234_5678);
        expect_v("midreset_dmem3", K_MEM, 3, 32'hFF80_8000);
        drain();
        run_cycles(2);
        expect_v("restart_pc", K_PC, 0, 32'd20);
        expect_v("restart_x1", K_RF, 1, 32'd8);
        drain();

        // EBREAK behaviour depends on the halt build option
        prog = '{EBREAK, enc_i(1, 0, 0, 1, O_IMM), enc_j(0, 0)};
        load_program();
        run_cycles(4);
`ifdef YOURCPU_HALT_EN
        expect_v("halt_pc", K_PC, 0, 32'h0);
        expect_v("halt_x1", K_RF, 1, 32'h0);
        expect_v("halt_flag", K_HALT, 0, 32'h1);
        drain();
        reset_n = 1'b1;
        run_cycles(1);
        reset_n = 1'b0;
        expect_v("halt_cleared", K_HALT, 0, 32'h0);
`else
        expect_v("ebreak_nop_pc", K_PC, 0, 32'd8);
        expect_v("ebreak_nop_x1", K_RF, 1, 32'h1);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
